// File: rtl/midi_parser.sv
// -----------------------------------------------------------------------------
// midi_parser
//
// This stage sits after the MIDI serial receiver and takes the stream of
// received bytes, one byte per byte_valid strobe. It builds complete
// channel-voice messages and supports running status. Real-time bytes
// (0xF8-0xFF) pass through the parser without any effect. For every complete
// Note On / Note Off, the block emits a one-cycle msg_valid pulse together
// with the decoded note number, velocity and channel. It also drives an LED
// word that follows the most recent sounding note.
//
// Ports
//   clk         single clock; all state updates on its rising edge
//   rst         synchronous, active-high reset
//   byte_in     received MIDI byte, sampled only while byte_valid=1
//   byte_valid  one-cycle strobe per received byte (back-to-back legal)
//   msg_valid   one-cycle pulse when a Note On / Note Off completes
//   note_on     1 = Note On with nonzero velocity, 0 = Note Off
//   note        note number of the last emitted message
//   velocity    velocity of the last emitted message
//   channel     channel nibble of the last emitted message
//   led_out     {gate, last note[6:0]}
//
// Parameters
//   CHANNEL     channel accepted when MIDI_CHANNEL_FILTER_EN is defined
//
// Build option
//   MIDI_CHANNEL_FILTER_EN  when defined, only messages whose channel equals
//                           CHANNEL are emitted. Messages on other channels
//                           are still parsed, including running status, but
//                           produce no output.
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no running status; data bytes are discarded (covers SysEx)
// DATA1  | status held; expecting the first data byte
// DATA2  | status and first data byte held; expecting the second data byte
// -----------------------------------------------------------------------------
module midi_parser #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       msg_valid,
  output logic       note_on,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] led_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA1 = 2'd1;
  localparam logic [1:0] DATA2 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] status;
  logic [7:0] status_nxt;
  logic [6:0] d1;
  logic [6:0] d1_nxt;

  // Classify the incoming byte.
  logic is_realtime;
  logic is_system;
  logic is_chan_status;
  logic is_data;

  assign is_realtime    = (byte_in[7:3] == 5'b11111);
  assign is_system      = (byte_in[7:3] == 5'b11110);
  assign is_chan_status = byte_in[7] && (byte_in[7:4] != 4'hF);
  assign is_data        = ~byte_in[7];

  // Decode the held status byte.
  logic [3:0] kind;
  logic       one_data_msg;
  logic       note_msg;

  assign kind         = status[7:4];
  assign one_data_msg = (kind == 4'hC) || (kind == 4'hD);
  assign note_msg     = (kind == 4'h8) || (kind == 4'h9);

  logic chan_ok;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign chan_ok = (status[3:0] == CHANNEL);
`else
  // All channels are accepted. CHANNEL still appears in the expression so
  // that both builds use the same parameter.
  assign chan_ok = (status[3:0] == CHANNEL) | 1'b1;
`endif

  logic emit;
  logic emit_on;

  assign emit    = byte_valid && is_data && (state == DATA2) && note_msg && chan_ok;
  assign emit_on = (kind == 4'h9) && (byte_in[6:0] != 7'd0);

  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    d1_nxt     = d1;
    if (byte_valid) begin
      if (is_realtime) begin
        state_nxt = state;
      end else if (is_system) begin
        status_nxt = 8'h00;
        state_nxt  = IDLE;
      end else if (is_chan_status) begin
        // A new status byte abandons any partial message.
        status_nxt = byte_in;
        state_nxt  = DATA1;
      end else if (is_data) begin
        case (state)
          IDLE: state_nxt = IDLE;
          DATA1: begin
            d1_nxt    = byte_in[6:0];
            // Program change and channel pressure finish after one data
            // byte and stay in DATA1 for running status.
            state_nxt = one_data_msg ? DATA1 : DATA2;
          end
          DATA2: state_nxt = DATA1;
          default: begin
            state_nxt  = IDLE;
            status_nxt = 8'h00;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      status    <= 8'h00;
      d1        <= 7'd0;
      msg_valid <= 1'b0;
      note_on   <= 1'b0;
      note      <= 7'd0;
      velocity  <= 7'd0;
      channel   <= 4'd0;
      led_out   <= 8'h00;
    end else begin
      state     <= state_nxt;
      status    <= status_nxt;
      d1        <= d1_nxt;
      msg_valid <= emit;
      if (emit) begin
        note     <= d1;
        velocity <= byte_in[6:0];
        channel  <= status[3:0];
        note_on  <= emit_on;
        // Only a Note Off for the note currently shown on the LEDs
        // turns the gate off.
        if (emit_on) begin
          led_out <= {1'b1, d1};
        end else if (d1 == led_out[6:0]) begin
          led_out[7] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/midi_parser.md
# midi_parser

Downstream stage of the MIDI serial receiver. Consumes the stream of received bytes (one byte per valid strobe) and assembles complete channel-voice messages, with running status and real-time byte filtering. Emits a one-cycle strobe per Note On / Note Off with decoded note number, velocity and channel. Also drives an 8-bit LED word tracking the most recent sounding note.

## Interface
- `CHANNEL`, default 0: 4-bit MIDI channel to accept when `MIDI_CHANNEL_FILTER_EN` is defined; unused otherwise.
- `clk` in 1: single clock domain; everything samples on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `byte_in` in 8: received MIDI byte; sampled only when `byte_valid`=1.
- `byte_valid` in 1: one-cycle strobe per received byte; back-to-back strobes on consecutive cycles are legal.
- `msg_valid` out 1: one-cycle pulse when a Note On / Note Off completes.
- `note_on` out 1: 1 = Note On with velocity≠0; 0 = Note Off (0x8n, or 0x9n with velocity 0).
- `note` out 7: note number of the last emitted message.
- `velocity` out 7: velocity of the last emitted message.
- `channel` out 4: channel nibble of the last emitted message.
- `led_out` out 8: {gate, last note[6:0]}.

## Operation
- State machine states: IDLE (no running status), DATA1 (expect first data byte), DATA2 (expect second data byte). Registers: `status[7:0]`, `d1[6:0]`.
- Byte classes (only when `byte_valid`=1):
  - Real-time 0xF8–0xFF: ignored entirely. No change to state, status or outputs, in any state.
  - System common / SysEx 0xF0–0xF7: running status cleared; go to IDLE.
  - Channel status 0x80–0xEF: latch into `status`; go to DATA1. Any partial message is abandoned.
  - Data 0x00–0x7F: handled per state.
- Data byte in IDLE: discarded; stay IDLE. This also covers SysEx payload.
- Data byte in DATA1: store in `d1`.
  - If `status[7:4]` is 0xC or 0xD: message complete, no output, stay in DATA1 (running status).
  - Otherwise go to DATA2.
- Data byte in DATA2: message complete; return to DATA1 (running status).
  - If `status[7:4]` is 0x8 or 0x9: emit.
  - 0xA, 0xB, 0xE: discarded.
- Emit:
  - `note`=`d1`, `velocity`=data byte, `channel`=`status[3:0]`.
  - `note_on` = (`status[7:4]`==0x9) && (velocity≠0).
  - Pulse `msg_valid`.
- Outputs `note`, `velocity`, `channel`, `note_on` hold their values until the next emit.
- LED gate:
  - Set on an emitted Note On.
  - Cleared on an emitted Note Off whose note equals the held LED note.
  - Note Off for any other note leaves `led_out` unchanged.
  - On a Note On, `led_out[6:0]` updates to the new note.

## Timing
- Reset: state IDLE, `status`=0x00, `d1`=0.
- Reset values of outputs: `msg_valid`=0, `note_on`=0, `note`=0, `velocity`=0, `channel`=0, `led_out`=0x00.
- Latency: `msg_valid` and all updated outputs are registered. They are valid the cycle after the `byte_valid` cycle carrying the final data byte. `led_out` updates in the same cycle.
- `msg_valid` is high for exactly one cycle per message.
- Consecutive messages on back-to-back bytes produce separate pulses.
- Reset asserted mid-message: the partial message is discarded and running status is cleared. No pulse is emitted.
- `byte_valid`=0: no state change; `msg_valid` deasserts.

## Configuration
- `MIDI_CHANNEL_FILTER_EN` defined: the emit step (outputs, pulse, LED) occurs only when `status[3:0]`==`CHANNEL`. Non-matching messages are still parsed, including running status, but produce no output.
- Not defined: all channels are emitted.

## Test plan
- Bytes 0x90,0x3C,0x64 → one `msg_valid` pulse with `note_on`=1, `note`=0x3C, `velocity`=0x64, `channel`=0, `led_out`=0xBC.
- Running status: 0x91,0x40,0x50,0x40,0x00 → two pulses:
  - first: `note_on`=1, `channel`=1;
  - second: `note_on`=0, `note`=0x40;
  - after the second pulse, `led_out`=0x40.
- 0x90,0x3C,0xF8,0x64 → single pulse with `note`=0x3C, `velocity`=0x64 (real-time byte transparent).
- 0x90,0x3C,0xF0,0x64,0x22 → no pulse; state IDLE. Also 0xC0,0x05,0x07 then 0xB0,0x07,0x7F → no pulses.
- Reset after 0x90,0x3C → following 0x64 produces no pulse; all outputs 0.
- With `MIDI_CHANNEL_FILTER_EN`, `CHANNEL`=2:
  - 0x93,0x30,0x40 → no pulse;
  - 0x92,0x30,0x40 → pulse with `channel`=2.
